// File: rtl/lfo_pkg.sv
// Shared LFO types and constants: DAC frame geometry, default DAC config nibble,
// and the SPI transmitter state encoding.
package lfo_pkg;

  localparam int unsigned DAC_DATA_W  = 12;
  localparam int unsigned DAC_FRAME_W = 16;

  // Channel A, unbuffered, 1x gain, output active
  localparam logic [3:0] DAC_CFG_DEFAULT = 4'b0011;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    LATCH,
    GAP
  } dac_state_t;

endpackage

// File: rtl/spi_tick_gen.sv
// Divide-by-CLK_DIV tick: one-cycle pulse every CLK_DIV enabled cycles,
// restarted from zero whenever clr is asserted or en is low.
module spi_tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || !en || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dac_spi_tx.sv
// Serialises one 12-bit sample per handshake into a 16-bit SPI mode-0 DAC write
// frame, then strobes LDAC. All outputs registered; busy for 36*CLK_DIV cycles.
module dac_spi_tx
  import lfo_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter logic [3:0]  CFG     = DAC_CFG_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DAC_DATA_W-1:0] sample,
  input  logic                  valid,
  output logic                  ready,
  output logic                  done,
  output logic                  cs_n,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  ldac_n
);

  dac_state_t             state_q, state_d;
  logic [DAC_FRAME_W-1:0] frame_q, frame_d;
  logic [4:0]             hcnt_q, hcnt_d;
  logic ready_q, ready_d, done_q, done_d, cs_n_q, cs_n_d;
  logic sclk_q, sclk_d, mosi_q, mosi_d, ldac_n_q, ldac_n_d;
  logic tick;

  spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q != IDLE),
    .clr  (state_d != state_q),
    .tick (tick)
  );

  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    hcnt_d   = hcnt_q;
    ready_d  = ready_q;
    done_d   = 1'b0;
    cs_n_d   = cs_n_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    ldac_n_d = ldac_n_q;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (valid && ready_q) begin
          frame_d = {CFG, sample};
          mosi_d  = CFG[3];
          cs_n_d  = 1'b0;
          ready_d = 1'b0;
          hcnt_d  = '0;
          state_d = SETUP;
        end
      end
      SETUP: if (tick) state_d = SHIFT;
      SHIFT: if (tick) begin
        // Even half-periods end in a rising edge, odd ones in a falling edge
        hcnt_d = hcnt_q + 5'd1;
        if (!hcnt_q[0]) begin
          sclk_d = 1'b1;
        end else begin
          sclk_d = 1'b0;
          if (hcnt_q == 5'd31) begin
            state_d = HOLD;
          end else begin
            frame_d = {frame_q[DAC_FRAME_W-2:0], 1'b0};
            mosi_d  = frame_q[DAC_FRAME_W-2];
          end
        end
      end
      HOLD: if (tick) begin
        cs_n_d   = 1'b1;
        ldac_n_d = 1'b0;
        state_d  = LATCH;
      end
      LATCH: if (tick) begin
        ldac_n_d = 1'b1;
        state_d  = GAP;
      end
      GAP: if (tick) begin
        ready_d = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      frame_q  <= '0;
      hcnt_q   <= '0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      ldac_n_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      hcnt_q   <= hcnt_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      cs_n_q   <= cs_n_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      ldac_n_q <= ldac_n_d;
    end
  end

  assign ready  = ready_q;
  assign done   = done_q;
  assign cs_n   = cs_n_q;
  assign sclk   = sclk_q;
  assign mosi   = mosi_q;
  assign ldac_n = ldac_n_q;

endmodule
